// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the timing generator, the pattern source and the DAC side.
// The slave modport is the pattern generator; the master modport drives timing and consumes pixels.
interface vga_pattern_gen_if #(
  parameter int W  = 12,
  parameter int CW = 8
);
  logic [1:0]    mode;
  logic          hsync_in;
  logic          vsync_in;
  logic          de_in;
  logic [W-1:0]  hdata;
  logic [W-1:0]  vdata;
  logic          hsync_out;
  logic          vsync_out;
  logic          de_out;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic          frame_start;

  modport master (
    output mode, hsync_in, vsync_in, de_in, hdata, vdata,
    input  hsync_out, vsync_out, de_out, red, green, blue, frame_start
  );

  modport slave (
    input  mode, hsync_in, vsync_in, de_in, hdata, vdata,
    output hsync_out, vsync_out, de_out, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern source (bars/grid/checker/bouncing box), fixed 2-cycle latency, no backpressure.
// Define PATTERN_BORDER_EN to overlay a white 1-pixel border on every pattern.
module vga_pattern_gen #(
  parameter int W        = 12,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int CW       = 8,
  parameter int BOX      = 64,
  parameter int STEP     = 4,
  parameter int VS_POL   = 1
) (
  input logic              clk,
  input logic              rst_n,
  vga_pattern_gen_if.slave vif
);

  localparam int   BAR_W  = H_ACTIVE / 8;
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_CHECK, PAT_BOX} pat_t;

  pat_t         mode_q;
  logic         vs_prev;
  logic         de_prev;
  logic         vs_edge;
  logic         de_rise;
  logic [W-1:0] bx;
  logic [W-1:0] by;
  logic         dir_x_dec;
  logic         dir_y_dec;
  logic [W:0]   x_nxt;
  logic [W:0]   y_nxt;
  logic [W-1:0] bar_cnt;
  logic [2:0]   bar_idx;
  logic [W-1:0] cur_cnt;
  logic [2:0]   cur_idx;

  // Stage-1 registers
  logic         hs1, vs1, de1;
  logic [2:0]   bar1;
  logic         grid1, check1, box1;
`ifdef PATTERN_BORDER_EN
  logic         border1;
`endif

  logic [CW-1:0] r_n, g_n, b_n;

  // Returns {new_dir_dec, new_pos}; W+1 bit arithmetic keeps the edge tests free of wrap-around.
  function automatic logic [W:0] bounce(input logic [W-1:0] pos, input logic dec,
                                        input logic [W:0] lim);
    logic [W:0] p;
    p = {1'b0, pos};
    if (!dec) begin
      if (p + (W+1)'(STEP + BOX) > lim)
        return {1'b1, W'(lim - (W+1)'(BOX))};
      return {1'b0, W'(p + (W+1)'(STEP))};
    end
    if (p < (W+1)'(STEP))
      return {1'b0, {W{1'b0}}};
    return {1'b1, W'(p - (W+1)'(STEP))};
  endfunction

  assign vs_edge = (vif.vsync_in == VS_ACT) && (vs_prev != VS_ACT);
  assign de_rise = vif.de_in && !de_prev;
  assign cur_cnt = de_rise ? '0 : bar_cnt;
  assign cur_idx = de_rise ? 3'd0 : bar_idx;
  assign x_nxt   = bounce(bx, dir_x_dec, (W+1)'(H_ACTIVE));
  assign y_nxt   = bounce(by, dir_y_dec, (W+1)'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev   <= ~VS_ACT;
      de_prev   <= 1'b0;
      mode_q    <= PAT_BARS;
      bx        <= '0;
      by        <= '0;
      dir_x_dec <= 1'b0;
      dir_y_dec <= 1'b0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
    end else begin
      vs_prev <= vif.vsync_in;
      de_prev <= vif.de_in;
      if (vs_edge) begin
        mode_q <= pat_t'(vif.mode);
        if (mode_q == PAT_BOX) begin
          {dir_x_dec, bx} <= x_nxt;
          {dir_y_dec, by} <= y_nxt;
        end
      end
      // Remainder pixels past the eighth bar stay in bar 7.
      if (vif.de_in) begin
        if (cur_cnt == W'(BAR_W - 1)) begin
          bar_cnt <= '0;
          bar_idx <= (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
        end else begin
          bar_cnt <= cur_cnt + W'(1);
          bar_idx <= cur_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      de1    <= 1'b0;
      bar1   <= '0;
      grid1  <= 1'b0;
      check1 <= 1'b0;
      box1   <= 1'b0;
`ifdef PATTERN_BORDER_EN
      border1 <= 1'b0;
`endif
    end else begin
      hs1    <= vif.hsync_in;
      vs1    <= vif.vsync_in;
      de1    <= vif.de_in;
      bar1   <= cur_idx;
      grid1  <= (vif.hdata[4:0] == 5'd0) || (vif.vdata[4:0] == 5'd0) ||
                (vif.hdata == W'(H_ACTIVE - 1)) || (vif.vdata == W'(V_ACTIVE - 1));
      check1 <= vif.hdata[5] ^ vif.vdata[5];
      box1   <= ({1'b0, vif.hdata} >= {1'b0, bx}) &&
                ({1'b0, vif.hdata} <  {1'b0, bx} + (W+1)'(BOX)) &&
                ({1'b0, vif.vdata} >= {1'b0, by}) &&
                ({1'b0, vif.vdata} <  {1'b0, by} + (W+1)'(BOX));
`ifdef PATTERN_BORDER_EN
      border1 <= (vif.hdata == '0) || (vif.hdata == W'(H_ACTIVE - 1)) ||
                 (vif.vdata == '0) || (vif.vdata == W'(V_ACTIVE - 1));
`endif
    end
  end

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode_q)
      PAT_BARS: begin
        // Bar order white, yellow, cyan, green, magenta, red, blue, black.
        r_n = {CW{!bar1[1]}};
        g_n = {CW{!bar1[2]}};
        b_n = {CW{!bar1[0]}};
      end
      PAT_GRID: begin
        r_n = {CW{grid1}};
        g_n = {CW{grid1}};
        b_n = {CW{grid1}};
      end
      PAT_CHECK: begin
        r_n = {CW{check1}};
        g_n = {CW{check1}};
        b_n = {CW{check1}};
      end
      default: begin
        r_n = {CW{box1}};
        b_n = {CW{!box1}};
      end
    endcase
`ifdef PATTERN_BORDER_EN
    if (border1) begin
      r_n = '1;
      g_n = '1;
      b_n = '1;
    end
`endif
    if (!de1) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vif.hsync_out   <= 1'b0;
      vif.vsync_out   <= 1'b0;
      vif.de_out      <= 1'b0;
      vif.red         <= '0;
      vif.green       <= '0;
      vif.blue        <= '0;
      vif.frame_start <= 1'b0;
    end else begin
      vif.hsync_out   <= hs1;
      vif.vsync_out   <= vs1;
      vif.de_out      <= de1;
      vif.red         <= r_n;
      vif.green       <= g_n;
      vif.blue        <= b_n;
      vif.frame_start <= vs_edge;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: per-cycle expected outputs queued at drive time,
// compared when they emerge (pixels after 2 edges, frame_start after 1).
`timescale 1ns/1ps
module tb_vga_pattern_gen;
  localparam int   W        = 12;
  localparam int   CW       = 8;
  localparam int   H_ACTIVE = 800;
  localparam int   V_ACTIVE = 600;
  localparam int   BOX      = 64;
  localparam int   STEP     = 4;
  localparam logic VS_ACT   = 1'b1;

  typedef struct {
    logic          rst;
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.W(W), .CW(CW)) vif ();

  vga_pattern_gen #(
    .W(W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CW(CW),
    .BOX(BOX), .STEP(STEP), .VS_POL(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vif(vif.slave)
  );

  exp_t pix_q[$];
  logic fs_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state
  int   m_mode = 0;
  int   m_bx = 0, m_by = 0;
  bit   m_dx_dec = 0, m_dy_dec = 0;
  logic m_vs_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic m_move(inout int p, inout bit dec, input int lim);
    if (!dec) begin
      if (p + STEP + BOX > lim) begin p = lim - BOX; dec = 1; end
      else p = p + STEP;
    end else if (p < STEP) begin
      p = 0; dec = 0;
    end else p = p - STEP;
  endtask

  function automatic logic [2:0] colour(input int md, input int h, input int v,
                                        input int bx, input int by);
    logic [2:0] rgb;
    int bar;
    bit on;
    rgb = 3'b000;
    case (md)
      0: begin
        bar = h / (H_ACTIVE / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: rgb = 3'b111;
          1: rgb = 3'b110;
          2: rgb = 3'b011;
          3: rgb = 3'b010;
          4: rgb = 3'b101;
          5: rgb = 3'b100;
          6: rgb = 3'b001;
          default: rgb = 3'b000;
        endcase
      end
      1: begin
        on = (h % 32 == 0) || (v % 32 == 0) || (h == H_ACTIVE - 1) || (v == V_ACTIVE - 1);
        rgb = {on, on, on};
      end
      2: begin
        on = ((h / 32) % 2) != ((v / 32) % 2);
        rgb = {on, on, on};
      end
      default: begin
        on = (h >= bx) && (h < bx + BOX) && (v >= by) && (v < by + BOX);
        rgb = on ? 3'b100 : 3'b001;
      end
    endcase
`ifdef PATTERN_BORDER_EN
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) rgb = 3'b111;
`endif
    return rgb;
  endfunction

  // Drive one pixel-clock of timing inputs, predict outputs, then check what emerges.
  task automatic step(input logic r, input logic hs, input logic vs, input logic de,
                      input int h, input int v);
    exp_t e, o;
    logic fs_e, fs_o;
    logic [2:0] c;
    rst_n        = r;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    vif.de_in    = de;
    vif.hdata    = W'(h);
    vif.vdata    = W'(v);
    fs_e = 1'b0;
    if (!r) begin
      m_mode = 0; m_bx = 0; m_by = 0; m_dx_dec = 0; m_dy_dec = 0;
      m_vs_prev = ~VS_ACT;
    end else begin
      if (vs == VS_ACT && m_vs_prev != VS_ACT) begin
        fs_e = 1'b1;
        if (m_mode == 3) begin
          m_move(m_bx, m_dx_dec, H_ACTIVE);
          m_move(m_by, m_dy_dec, V_ACTIVE);
        end
        m_mode = int'(vif.mode);
      end
      m_vs_prev = vs;
    end
    c = colour(m_mode, h, v, m_bx, m_by);
    e.rst = !r;
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    e.r   = (de && c[2]) ? '1 : '0;
    e.g   = (de && c[1]) ? '1 : '0;
    e.b   = (de && c[0]) ? '1 : '0;
    pix_q.push_back(e);
    fs_q.push_back(fs_e);

    @(posedge clk);
    #1;
    fs_o = fs_q.pop_front();
    chk("frame_start", 32'(vif.frame_start), 32'(fs_o));
    if (pix_q.size() == 2) begin
      o = pix_q.pop_front();
      if (o.rst || !r) begin
        o.hs = 0; o.vs = 0; o.de = 0; o.r = '0; o.g = '0; o.b = '0;
      end
      chk("hsync_out", 32'(vif.hsync_out), 32'(o.hs));
      chk("vsync_out", 32'(vif.vsync_out), 32'(o.vs));
      chk("de_out",    32'(vif.de_out),    32'(o.de));
      chk("red",       32'(vif.red),       32'(o.r));
      chk("green",     32'(vif.green),     32'(o.g));
      chk("blue",      32'(vif.blue),      32'(o.b));
    end
    @(negedge clk);
  endtask

  task automatic line(input int v);
    for (int h = 0; h < H_ACTIVE; h++) step(1, 0, 0, 1, h, v);
    step(1, 1, 0, 0, 0, v);
    step(1, 1, 0, 0, 0, v);
    step(1, 0, 0, 0, 0, v);
    step(1, 0, 0, 0, 0, v);
  endtask

  task automatic frame();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic probe(input int h, input int v);
    step(1, 0, 0, 1, h, v);
    step(1, 0, 0, 0, h, v);
  endtask

  initial begin
    vif.mode = 2'd0;
    vif.hsync_in = 0; vif.vsync_in = 0; vif.de_in = 0;
    vif.hdata = '0; vif.vdata = '0;

    // Reset with the timing generator running
    for (int i = 0; i < 5; i++) step(0, 1'(i % 2), 0, 1, i, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);

    // Colour bars
    frame();
    line(10);
    line(11);

    // Mode switch mid-frame: bars persist until the next frame start
    vif.mode = 2'd1;
    line(300);
    frame();
    line(0);
    line(31);
    probe(799, 599);
    probe(5, 599);
    probe(33, 33);

    // Checkerboard
    vif.mode = 2'd2;
    frame();
    probe(0, 0);
    probe(32, 0);
    probe(32, 32);
    probe(31, 63);
    probe(64, 100);

    // Bouncing box: long enough to hit both right and bottom edges
    vif.mode = 2'd3;
    frame();
    for (int f = 0; f < 200; f++) begin
      frame();
      probe(m_bx, m_by);
      probe(m_bx + BOX - 1, m_by + BOX - 1);
      if (m_bx > 0) probe(m_bx - 1, m_by + 1);
      if (m_bx + BOX < H_ACTIVE) probe(m_bx + BOX, m_by + 1);
      if (m_by + BOX < V_ACTIVE) probe(m_bx + 1, m_by + BOX);
    end
    probe(0, 300);
    probe(799, 0);
    probe(1, 300);

    // Reset mid-frame: box returns to origin, mode falls back to bars
    probe(400, 300);
    step(0, 0, 0, 1, 401, 300);
    step(0, 0, 0, 1, 402, 300);
    step(1, 0, 0, 0, 0, 300);
    step(1, 0, 0, 0, 0, 300);
    line(301);
    frame();
    probe(0, 0);
    probe(BOX - 1, BOX - 1);
    probe(BOX, 10);
    probe(10, BOX);
    frame();
    probe(STEP, STEP);
    probe(STEP - 1, 10);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
